sram_dp_be: RTL and testbench
=============================

# sram_dp_be

Simple dual-port SRAM with one write port and one read port sharing one clock. Adds per-byte write enables, a selectable read-during-write collision mode, an optional output pipeline register with a read-valid strobe, and a post-reset zero-clear sequencer. It is the general-purpose successor to the single-port latch-mode SRAM. It backs caches, tag stores and buffers in the core, where a write and an independent read must proceed in the same cycle.

## Interface
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- N_ENTRIES, 128: number of words; need not be a power of two; address width AW = $clog2(N_ENTRIES).
- WRITE_FIRST, 1: collision mode; 1 = a same-address read returns the newly written bytes; 0 = it returns the old word.
- OUT_REG, 0: 1 adds one output register stage to the read path.
- INIT_CLEAR, 1: 1 = zero every entry after reset before accepting traffic.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- init_done_o  out  1  high when the block accepts requests.
- wa_en_i  in  1  write request.
- wa_addr_i  in  AW  write address.
- wa_be_i  in  DATA_WIDTH/8  byte enables; bit k covers data bits [8k+7:8k].
- wa_data_i  in  DATA_WIDTH  write data.
- rb_en_i  in  1  read request.
- rb_addr_i  in  AW  read address.
- rb_data_o  out  DATA_WIDTH  read data; holds the last value between reads.
- rb_valid_o  out  1  one-cycle pulse marking new rb_data_o.

## Operation
- FSM states:
  - RESET: held while rst_i is high.
  - CLEAR: only when INIT_CLEAR=1.
  - READY.
- Transitions:
  - On rst_i deassertion, the next edge enters CLEAR (INIT_CLEAR=1) or READY (INIT_CLEAR=0).
  - CLEAR writes all-zero to address cnt, one entry per cycle, with cnt running 0..N_ENTRIES-1.
  - After the write to N_ENTRIES-1, CLEAR goes to READY.
- init_done_o = 1 only in READY.
- In CLEAR:
  - wa_en_i and rb_en_i are ignored: writes are dropped and no rb_valid_o is produced.
  - Requesters must wait for init_done_o.
- Write, READY, wa_en_i=1: for each k with wa_be_i[k]=1, byte k of RAM[wa_addr_i] takes byte k of wa_data_i; other bytes are unchanged. wa_be_i=0 is a no-op.
- Read, READY, rb_en_i=1: returns RAM[rb_addr_i] and produces one rb_valid_o pulse per accepted read.
- Collision (wa_en_i and rb_en_i both high with equal addresses):
  - WRITE_FIRST=1: the result is the merged word, enabled bytes from wa_data_i and the rest old.
  - WRITE_FIRST=0: the result is the pre-write word.
  - The RAM is updated in both modes.
- Out-of-range address (>= N_ENTRIES, only possible when N_ENTRIES is not a power of two):
  - A write is dropped.
  - A read returns zero, with rb_valid_o asserted normally.
- rst_i does not clear RAM contents. Only INIT_CLEAR zeroes them.

## Timing
- Reset values, asynchronous:
  - rb_data_o = 0, rb_valid_o = 0, init_done_o = 0.
  - CLEAR counter = 0; the OUT_REG stage data and valid = 0.
- Clear duration: READY (init_done_o=1) is reached N_ENTRIES+1 edges after rst_i falls (1 edge to enter CLEAR, then N_ENTRIES clear writes). With INIT_CLEAR=0 it is 1 edge.
- Read latency:
  - OUT_REG=0: a request sampled at edge t gives rb_data_o and rb_valid_o=1 after edge t, lasting one cycle.
  - OUT_REG=1: after edge t+1.
- Back-to-back reads every cycle give one valid pulse per cycle (full throughput).
- A write at edge t is visible to a non-colliding read issued at edge t+1.
- rst_i asserted mid-CLEAR or mid-read:
  - All outputs drop to reset values immediately and in-flight reads are discarded.
  - After release, CLEAR restarts from address 0.
- Requests presented in the same cycle that init_done_o first rises are accepted.

## Test plan
- Init clear, DATA_WIDTH=32, N_ENTRIES=128, INIT_CLEAR=1: release rst_i, then read all addresses -> init_done_o rises exactly 129 edges after release; every read returns 0x00000000.
- Byte-enable write: write 0xAABBCCDD with be=4'hF to addr 5, then 0x11223344 with be=4'b0101 -> read addr 5 returns 0xAA22CC44, valid 1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1).
- Collision: addr 9 holds 0x0; same-cycle write 0xFFFFFFFF with be=4'b0011 and read of addr 9 -> WRITE_FIRST=1 returns 0x0000FFFF, WRITE_FIRST=0 returns 0x00000000; a subsequent read returns 0x0000FFFF in both modes.
- Streaming: 16 consecutive reads of addrs 0..15 after writing value = addr*3 -> 16 consecutive valid pulses in address order, no gaps; rb_data_o holds 45 after the stream.
- Reset mid-clear: assert rst_i 40 cycles into CLEAR after writing a pattern pre-reset with INIT_CLEAR=0 build, then release -> outputs 0 during reset; CLEAR restarts from 0 and takes a full 129 edges; requests during CLEAR produce no valid and do not modify RAM.
- Non-power-of-two depth, N_ENTRIES=100: write to addr 110, read 110 and 99 -> read of 110 returns 0 with valid; addr 99 is unaffected; init_done_o rises 101 edges after reset release.

Source files
------------

// File: rtl/sram_dp_be.sv
// sram_dp_be: simple dual-port SRAM (one write port, one read port, one clock)
// with per-byte write enables, selectable read-during-write behaviour, an
// optional read output register and a post-reset zero-clear sequencer.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset (RAM contents are kept)
//   init_done_o  high once the block accepts requests
//   wa_en_i      write request
//   wa_addr_i    write address
//   wa_be_i      byte enables, bit k covers wa_data_i[8k+7:8k]
//   wa_data_i    write data
//   rb_en_i      read request
//   rb_addr_i    read address
//   rb_data_o    read data, holds between reads
//   rb_valid_o   one-cycle pulse per accepted read
module sram_dp_be #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_ENTRIES  = 128,
  parameter int unsigned WRITE_FIRST = 1,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned INIT_CLEAR = 1,
  localparam int unsigned AW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1,
  localparam int unsigned NB = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  init_done_o,
  input  logic                  wa_en_i,
  input  logic [AW-1:0]         wa_addr_i,
  input  logic [NB-1:0]         wa_be_i,
  input  logic [DATA_WIDTH-1:0] wa_data_i,
  input  logic                  rb_en_i,
  input  logic [AW-1:0]         rb_addr_i,
  output logic [DATA_WIDTH-1:0] rb_data_o,
  output logic                  rb_valid_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N_ENTRIES - 1);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic                  clr_we_c;
  logic                  wr_in_range_c, rd_in_range_c;
  logic                  wr_ok_c, rd_ok_c, collide_c;
  logic [DATA_WIDTH-1:0] mem_q [N_ENTRIES];
  logic [DATA_WIDTH-1:0] old_c, merged_c, rd_word_c;
  logic                  src_valid_c;
  logic [DATA_WIDTH-1:0] src_data_c;

  // State and clear-counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      init_done_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_o <= (state_d == ST_READY);
    end
  end

  // Next-state logic: RESET -> (CLEAR sweep) -> READY
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_c = 1'b0;
    case (state_q)
      ST_RESET: begin
        cnt_d   = '0;
        state_d = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
      end
      ST_CLEAR: begin
        clr_we_c = 1'b1;
        if (cnt_q == LAST_ADDR) state_d = ST_READY;
        else                    cnt_d   = cnt_q + AW'(1);
      end
      ST_READY: ;
      default: state_d = ST_RESET;
    endcase
  end

  // Range checks only exist when the depth leaves unused address codes
  if (N_ENTRIES == (2 ** AW)) begin : g_pow2
    assign wr_in_range_c = 1'b1;
    assign rd_in_range_c = 1'b1;
  end else begin : g_npow2
    localparam logic [AW:0] DEPTH = (AW + 1)'(N_ENTRIES);
    assign wr_in_range_c = ({1'b0, wa_addr_i} < DEPTH);
    assign rd_in_range_c = ({1'b0, rb_addr_i} < DEPTH);
  end

  assign wr_ok_c   = (state_q == ST_READY) && wa_en_i && wr_in_range_c;
  assign rd_ok_c   = (state_q == ST_READY) && rb_en_i;
  assign collide_c = wr_ok_c && (wa_addr_i == rb_addr_i);

  // RAM array: clear sweep has priority; never reset
  always_ff @(posedge clk_i) begin
    if (clr_we_c) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_ok_c) begin
      for (int k = 0; k < NB; k++) begin
        if (wa_be_i[k]) mem_q[wa_addr_i][8*k +: 8] <= wa_data_i[8*k +: 8];
      end
    end
  end

  // Read word, with write-first bypass of enabled bytes on collision
  always_comb begin
    old_c    = rd_in_range_c ? mem_q[rb_addr_i] : '0;
    merged_c = old_c;
    for (int k = 0; k < NB; k++) begin
      if (wa_be_i[k]) merged_c[8*k +: 8] = wa_data_i[8*k +: 8];
    end
    rd_word_c = old_c;
    if (!rd_in_range_c)                    rd_word_c = '0;
    else if ((WRITE_FIRST != 0) && collide_c) rd_word_c = merged_c;
  end

  // Optional extra output stage
  if (OUT_REG != 0) begin : g_pipe
    logic                  pipe_valid_q;
    logic [DATA_WIDTH-1:0] pipe_data_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        pipe_valid_q <= 1'b0;
        pipe_data_q  <= '0;
      end else begin
        pipe_valid_q <= rd_ok_c;
        if (rd_ok_c) pipe_data_q <= rd_word_c;
      end
    end
    assign src_valid_c = pipe_valid_q;
    assign src_data_c  = pipe_data_q;
  end else begin : g_nopipe
    assign src_valid_c = rd_ok_c;
    assign src_data_c  = rd_word_c;
  end

  // Output register: data holds between reads
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rb_valid_o <= 1'b0;
      rb_data_o  <= '0;
    end else begin
      rb_valid_o <= src_valid_c;
      if (src_valid_c) rb_data_o <= src_data_c;
    end
  end

endmodule

// File: tb/tb_sram_dp_be.sv
// Testbench for sram_dp_be. Three instances:
//   0: N=128, write-first, no output reg, init clear
//   1: N=100, read-first,  output reg,    init clear
//   2: N=128, write-first, output reg,    no init clear
module tb_sram_dp_be;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rst       [ND];
  logic        init_done [ND];
  logic        wa_en     [ND];
  logic [6:0]  wa_addr   [ND];
  logic [3:0]  wa_be     [ND];
  logic [31:0] wa_data   [ND];
  logic        rb_en     [ND];
  logic [6:0]  rb_addr   [ND];
  logic [31:0] rb_data   [ND];
  logic        rb_valid  [ND];

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_w [128];

  always #5 clk = ~clk;

  sram_dp_be #(.DATA_WIDTH(32), .N_ENTRIES(128), .WRITE_FIRST(1), .OUT_REG(0), .INIT_CLEAR(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .init_done_o(init_done[0]),
    .wa_en_i(wa_en[0]), .wa_addr_i(wa_addr[0]), .wa_be_i(wa_be[0]), .wa_data_i(wa_data[0]),
    .rb_en_i(rb_en[0]), .rb_addr_i(rb_addr[0]), .rb_data_o(rb_data[0]), .rb_valid_o(rb_valid[0]));

  sram_dp_be #(.DATA_WIDTH(32), .N_ENTRIES(100), .WRITE_FIRST(0), .OUT_REG(1), .INIT_CLEAR(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .init_done_o(init_done[1]),
    .wa_en_i(wa_en[1]), .wa_addr_i(wa_addr[1]), .wa_be_i(wa_be[1]), .wa_data_i(wa_data[1]),
    .rb_en_i(rb_en[1]), .rb_addr_i(rb_addr[1]), .rb_data_o(rb_data[1]), .rb_valid_o(rb_valid[1]));

  sram_dp_be #(.DATA_WIDTH(32), .N_ENTRIES(128), .WRITE_FIRST(1), .OUT_REG(1), .INIT_CLEAR(0)) u_dut2 (
    .clk_i(clk), .rst_i(rst[2]), .init_done_o(init_done[2]),
    .wa_en_i(wa_en[2]), .wa_addr_i(wa_addr[2]), .wa_be_i(wa_be[2]), .wa_data_i(wa_data[2]),
    .rb_en_i(rb_en[2]), .rb_addr_i(rb_addr[2]), .rb_data_o(rb_data[2]), .rb_valid_o(rb_valid[2]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int clr_edges_of(input int d);
    case (d)
      0:       return 129;
      1:       return 101;
      default: return 1;
    endcase
  endfunction

  // Single write; starts and ends on a falling edge
  task automatic wr(input int d, input logic [6:0] a, input logic [3:0] be, input logic [31:0] data);
    wa_en[d] = 1'b1; wa_addr[d] = a; wa_be[d] = be; wa_data[d] = data;
    @(negedge clk);
    wa_en[d] = 1'b0; wa_be[d] = 4'h0;
  endtask

  // Single read; returns the output after the instance's latency
  task automatic rd(input int d, input logic [6:0] a, output logic [31:0] data,
                    output logic valid, output logic early);
    rb_en[d] = 1'b1; rb_addr[d] = a;
    @(negedge clk);
    rb_en[d] = 1'b0;
    early = rb_valid[d];
    if (lat_of(d) == 2) @(negedge clk);
    data  = rb_data[d];
    valid = rb_valid[d];
  endtask

  // Back-to-back reads of addresses 0..n-1 checked against exp_w
  task automatic stream_check(input int d, input int n, input string tag);
    int L = lat_of(d);
    int j;
    for (int k = 0; k < n + L; k++) begin
      if (k < n) begin rb_en[d] = 1'b1; rb_addr[d] = 7'(k); end
      else rb_en[d] = 1'b0;
      @(negedge clk);
      j = k + 1 - L;
      if (j >= 0 && j < n) begin
        checks++;
        if (rb_valid[d] !== 1'b1 || rb_data[d] !== exp_w[j]) begin
          errors++;
          $display("FAIL %s dut%0d addr %0d: got valid=%b data=%h expected valid=1 data=%h",
                   tag, d, j, rb_valid[d], rb_data[d], exp_w[j]);
        end
      end
    end
    rb_en[d] = 1'b0;
    checks++;
    if (rb_valid[d] !== 1'b0 || rb_data[d] !== exp_w[n-1]) begin
      errors++;
      $display("FAIL %s_hold dut%0d: got valid=%b data=%h expected valid=0 data=%h",
               tag, d, rb_valid[d], rb_data[d], exp_w[n-1]);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < ND; d++) begin
      rst[d] = 1'b1; wa_en[d] = 1'b0; wa_addr[d] = '0; wa_be[d] = '0; wa_data[d] = '0;
      rb_en[d] = 1'b0; rb_addr[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (init_done[d] !== 1'b0 || rb_valid[d] !== 1'b0 || rb_data[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset dut%0d: got init=%b valid=%b data=%h expected 0 0 0",
                 d, init_done[d], rb_valid[d], rb_data[d]);
      end
    end
  endtask

  task automatic test_init_clear();
    int  edges [ND];
    bit  seen  [ND];
    for (int d = 0; d < ND; d++) begin edges[d] = 0; seen[d] = 1'b0; rst[d] = 1'b0; end
    for (int e = 1; e <= 300; e++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++)
        if (!seen[d] && init_done[d] === 1'b1) begin seen[d] = 1'b1; edges[d] = e; end
      if (seen[0] && seen[1] && seen[2]) break;
    end
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (edges[d] != clr_edges_of(d)) begin
        errors++;
        $display("FAIL init_edges dut%0d: got %0d expected %0d", d, edges[d], clr_edges_of(d));
      end
    end
    for (int k = 0; k < 128; k++) exp_w[k] = 32'h0;
    stream_check(0, 128, "clear_read");
    stream_check(1, 100, "clear_read");
  endtask

  task automatic test_byte_enable(input int d);
    logic [31:0] data; logic valid, early;
    wr(d, 7'd5, 4'hF, 32'hAABBCCDD);
    wr(d, 7'd5, 4'b0101, 32'h11223344);
    wr(d, 7'd5, 4'h0, 32'hFFFFFFFF);
    rd(d, 7'd5, data, valid, early);
    checks++;
    if (valid !== 1'b1 || data !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL byte_enable dut%0d: got valid=%b data=%h expected valid=1 data=aa22cc44",
               d, valid, data);
    end
    if (lat_of(d) == 2) begin
      checks++;
      if (early !== 1'b0) begin
        errors++;
        $display("FAIL early_valid dut%0d: got %b expected 0", d, early);
      end
    end
  endtask

  task automatic test_collision(input int d);
    logic [31:0] data, exp; logic valid, early;
    wr(d, 7'd9, 4'hF, 32'h0);
    wa_en[d] = 1'b1; wa_addr[d] = 7'd9; wa_be[d] = 4'b0011; wa_data[d] = 32'hFFFFFFFF;
    rb_en[d] = 1'b1; rb_addr[d] = 7'd9;
    @(negedge clk);
    wa_en[d] = 1'b0; wa_be[d] = 4'h0; rb_en[d] = 1'b0;
    if (lat_of(d) == 2) @(negedge clk);
    exp = (d == 1) ? 32'h0000_0000 : 32'h0000_FFFF;
    checks++;
    if (rb_valid[d] !== 1'b1 || rb_data[d] !== exp) begin
      errors++;
      $display("FAIL collision dut%0d: got valid=%b data=%h expected valid=1 data=%h",
               d, rb_valid[d], rb_data[d], exp);
    end
    rd(d, 7'd9, data, valid, early);
    checks++;
    if (valid !== 1'b1 || data !== 32'h0000FFFF) begin
      errors++;
      $display("FAIL collision_after dut%0d: got valid=%b data=%h expected valid=1 data=0000ffff",
               d, valid, data);
    end
  endtask

  task automatic test_back_to_back(input int d);
    for (int k = 0; k < 16; k++) begin
      exp_w[k] = 32'(k * 3);
      wr(d, 7'(k), 4'hF, 32'(k * 3));
    end
    stream_check(d, 16, "stream");
  endtask

  task automatic test_out_of_range();
    logic [31:0] data; logic valid, early;
    wr(1, 7'd99, 4'hF, 32'h12345678);
    wr(1, 7'd110, 4'hF, 32'hDEADBEEF);
    rd(1, 7'd110, data, valid, early);
    checks++;
    if (valid !== 1'b1 || data !== 32'h0) begin
      errors++;
      $display("FAIL oor_read dut1: got valid=%b data=%h expected valid=1 data=00000000", valid, data);
    end
    rd(1, 7'd99, data, valid, early);
    checks++;
    if (valid !== 1'b1 || data !== 32'h12345678) begin
      errors++;
      $display("FAIL last_entry dut1: got valid=%b data=%h expected valid=1 data=12345678", valid, data);
    end
  endtask

  task automatic test_reset_no_clear();
    logic [31:0] data; logic valid, early;
    wr(2, 7'd40, 4'hF, 32'hCAFEF00D);
    rst[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (init_done[2] !== 1'b0 || rb_valid[2] !== 1'b0 || rb_data[2] !== 32'h0) begin
      errors++;
      $display("FAIL reset2 dut2: got init=%b valid=%b data=%h expected 0 0 0",
               init_done[2], rb_valid[2], rb_data[2]);
    end
    rst[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (init_done[2] !== 1'b1) begin
      errors++;
      $display("FAIL ready_1edge dut2: got init=%b expected 1", init_done[2]);
    end
    rd(2, 7'd40, data, valid, early);
    checks++;
    if (valid !== 1'b1 || data !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL ram_kept dut2: got valid=%b data=%h expected valid=1 data=cafef00d", valid, data);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [31:0] data; logic valid, early;
    int edges;
    int bad_valid;
    wr(0, 7'd20, 4'hF, 32'h5A5A5A5A);
    // reset lands just after the edge that launched a read
    rb_en[0] = 1'b1; rb_addr[0] = 7'd20;
    @(posedge clk);
    #2 rst[0] = 1'b1;
    rb_en[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (init_done[0] !== 1'b0 || rb_valid[0] !== 1'b0 || rb_data[0] !== 32'h0) begin
      errors++;
      $display("FAIL async_reset dut0: got init=%b valid=%b data=%h expected 0 0 0",
               init_done[0], rb_valid[0], rb_data[0]);
    end
    rst[0] = 1'b0;
    bad_valid = 0;
    for (int c = 0; c < 40; c++) begin
      wa_en[0] = 1'b1; wa_addr[0] = 7'd0; wa_be[0] = 4'hF; wa_data[0] = 32'hFFFFFFFF;
      rb_en[0] = 1'b1; rb_addr[0] = 7'd20;
      @(negedge clk);
      if (rb_valid[0] !== 1'b0) bad_valid++;
    end
    rst[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (init_done[0] !== 1'b0 || rb_valid[0] !== 1'b0 || rb_data[0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_clear dut0: got init=%b valid=%b data=%h expected 0 0 0",
               init_done[0], rb_valid[0], rb_data[0]);
    end
    rst[0] = 1'b0;
    edges = 0;
    for (int e = 1; e <= 300; e++) begin
      @(negedge clk);
      if (init_done[0] === 1'b1) begin edges = e; break; end
      if (rb_valid[0] !== 1'b0) bad_valid++;
    end
    wa_en[0] = 1'b0; wa_be[0] = 4'h0; rb_en[0] = 1'b0;
    checks++;
    if (edges != 129) begin
      errors++;
      $display("FAIL restart_edges dut0: got %0d expected 129", edges);
    end
    checks++;
    if (bad_valid != 0) begin
      errors++;
      $display("FAIL clear_valid dut0: got %0d valid pulses expected 0", bad_valid);
    end
    rd(0, 7'd0, data, valid, early);
    checks++;
    if (valid !== 1'b1 || data !== 32'h0) begin
      errors++;
      $display("FAIL clear_drop_write dut0: got valid=%b data=%h expected valid=1 data=00000000", valid, data);
    end
    rd(0, 7'd20, data, valid, early);
    checks++;
    if (valid !== 1'b1 || data !== 32'h0) begin
      errors++;
      $display("FAIL cleared_pattern dut0: got valid=%b data=%h expected valid=1 data=00000000", valid, data);
    end
  endtask

  initial begin
    test_reset();
    test_init_clear();
    for (int d = 0; d < ND; d++) test_byte_enable(d);
    for (int d = 0; d < ND; d++) test_collision(d);
    for (int d = 0; d < ND; d++) test_back_to_back(d);
    test_out_of_range();
    test_reset_no_clear();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
